// File: rtl/impulso_pkg.sv
// Shared definitions for the impulse-to-pulse stretcher: state encoding,
// status counter width and a constant-friendly ceil(log2) helper.
package impulso_pkg;

   // The HUECO parameter of the top shares its name with the gap state,
   // so the state literals carry an EST_ prefix to keep both visible.
   typedef enum logic [1:0] {
      EST_REPOSO = 2'd0,
      EST_ACTIVO = 2'd1,
      EST_HUECO  = 2'd2
   } estado_t;

   localparam int CUENTA_W = 8;

   function automatic int clog2(input int valor);
      int r;
      r = 0;
      for (int i = 0; i < 31; i++) begin
         if ((1 << i) < valor) r = i + 1;
      end
      return r;
   endfunction

endpackage

// File: rtl/contador_descendente.sv
// Loadable down-counter that saturates at zero; shared by the pulse and
// gap countdowns of the stretcher.
module contador_descendente #(
   parameter int W = 8
)(
   input  logic         clk,
   input  logic         rst_n,
   input  logic         carga,
   input  logic [W-1:0] valor,
   input  logic         habilita,
   output logic         cero
);

   logic [W-1:0] cuenta_reg;

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         cuenta_reg <= '0;
      end else if (carga) begin
         cuenta_reg <= valor;
      end else if (habilita && (cuenta_reg != '0)) begin
         cuenta_reg <= cuenta_reg - 1'b1;
      end
   end

   assign cero = (cuenta_reg == '0);

endmodule

// File: rtl/impulso_a_pulso.sv
// Stretches a one-cycle impulse into a fixed-length pulse, with optional
// hold-off gap and retrigger, plus busy / lost / accepted-count status.
module impulso_a_pulso
   import impulso_pkg::*;
#(
   parameter int ANCHO     = 250,
   parameter int HUECO     = 0,
   parameter int RETRIGGER = 0
)(
   input  logic                clock1k,
   input  logic                resetN,
   input  logic                impulso,
   output logic                pulso,
   output logic                ocupado,
   output logic                perdido,
   output logic [CUENTA_W-1:0] cuentaPulsos
);

   if (ANCHO < 1) begin : g_ancho_invalido
      $error("impulso_a_pulso: ANCHO must be >= 1");
   end
   if (HUECO < 0) begin : g_hueco_invalido
      $error("impulso_a_pulso: HUECO must be >= 0");
   end

   localparam int MAXIMO = (ANCHO > HUECO) ? ANCHO : HUECO;
   localparam int CNT_W  = clog2(MAXIMO + 1);
   localparam logic [CNT_W-1:0] VAL_ANCHO = CNT_W'(ANCHO - 1);
   localparam logic [CNT_W-1:0] VAL_HUECO = (HUECO > 0) ? CNT_W'(HUECO - 1) : '0;

   estado_t estado_reg, estado_next;
   logic    carga, habilita, cero, acepta;
   logic [CNT_W-1:0] valor;

   logic                pulso_reg, pulso_next;
   logic                ocupado_reg, ocupado_next;
   logic                perdido_reg, perdido_next;
   logic [CUENTA_W-1:0] cuenta_reg, cuenta_next;

   contador_descendente #(.W(CNT_W)) u_contador (
      .clk      (clock1k),
      .rst_n    (resetN),
      .carga    (carga),
      .valor    (valor),
      .habilita (habilita),
      .cero     (cero)
   );

   // State and status registers; reset clears everything immediately,
   // which also truncates a pulse in flight.
   always_ff @(posedge clock1k or negedge resetN) begin
      if (!resetN) begin
         estado_reg  <= EST_REPOSO;
         pulso_reg   <= 1'b0;
         ocupado_reg <= 1'b0;
         perdido_reg <= 1'b0;
         cuenta_reg  <= '0;
      end else begin
         estado_reg  <= estado_next;
         pulso_reg   <= pulso_next;
         ocupado_reg <= ocupado_next;
         perdido_reg <= perdido_next;
         cuenta_reg  <= cuenta_next;
      end
   end

   always_comb begin
      estado_next  = estado_reg;
      carga        = 1'b0;
      valor        = VAL_ANCHO;
      habilita     = 1'b0;
      acepta       = 1'b0;
      perdido_next = 1'b0;
      case (estado_reg)
         EST_REPOSO: begin
            if (impulso) begin
               estado_next = EST_ACTIVO;
               carga       = 1'b1;
               acepta      = 1'b1;
            end
         end
         EST_ACTIVO: begin
            if (impulso && (RETRIGGER != 0)) begin
               carga = 1'b1;
            end else begin
               perdido_next = impulso;
               if (!cero) begin
                  habilita = 1'b1;
               end else if (HUECO > 0) begin
                  estado_next = EST_HUECO;
                  carga       = 1'b1;
                  valor       = VAL_HUECO;
               end else begin
                  estado_next = EST_REPOSO;
               end
            end
         end
         EST_HUECO: begin
            perdido_next = impulso;
            if (cero) estado_next = EST_REPOSO;
            else      habilita    = 1'b1;
         end
         default: estado_next = EST_REPOSO;
      endcase
   end

   // Outputs are registered copies derived from the state being entered.
   always_comb begin
      pulso_next   = (estado_next == EST_ACTIVO);
      ocupado_next = (estado_next != EST_REPOSO);
      cuenta_next  = acepta ? cuenta_reg + 1'b1 : cuenta_reg;
   end

   assign pulso        = pulso_reg;
   assign ocupado      = ocupado_reg;
   assign perdido      = perdido_reg;
   assign cuentaPulsos = cuenta_reg;

endmodule

// File: tb/tb_impulso_a_pulso.sv
// Scoreboard bench for impulso_a_pulso: three configurations run side by
// side against a remaining-cycles reference model.
module tb_impulso_a_pulso;

   localparam int ANCHO_T [3] = '{4, 4, 1};
   localparam int HUECO_T [3] = '{2, 0, 0};
   localparam int RET_T   [3] = '{0, 1, 0};

   typedef struct packed {
      logic       p;
      logic       o;
      logic       l;
      logic [7:0] c;
   } esp_t;
   typedef esp_t [2:0] trio_t;

   logic       clk = 1'b0;
   logic [2:0] rstn, imp, pul, ocu, per;
   logic [7:0] cnt [3];

   int    checks = 0, errors = 0;
   int    pl [3], gl [3], cuenta [3];
   bit    lost [3];
   int    hi_p [3], hi_o [3], hi_l [3];
   trio_t sb [$];
   string nombres [3] = '{"A", "B", "C"};

   always #5 clk = ~clk;

   impulso_a_pulso #(.ANCHO(4), .HUECO(2), .RETRIGGER(0)) dut_a (
      .clock1k(clk), .resetN(rstn[0]), .impulso(imp[0]), .pulso(pul[0]),
      .ocupado(ocu[0]), .perdido(per[0]), .cuentaPulsos(cnt[0]));
   impulso_a_pulso #(.ANCHO(4), .HUECO(0), .RETRIGGER(1)) dut_b (
      .clock1k(clk), .resetN(rstn[1]), .impulso(imp[1]), .pulso(pul[1]),
      .ocupado(ocu[1]), .perdido(per[1]), .cuentaPulsos(cnt[1]));
   impulso_a_pulso #(.ANCHO(1), .HUECO(0), .RETRIGGER(0)) dut_c (
      .clock1k(clk), .resetN(rstn[2]), .impulso(imp[2]), .pulso(pul[2]),
      .ocupado(ocu[2]), .perdido(per[2]), .cuentaPulsos(cnt[2]));

   task automatic chequear(input string tag, input logic [31:0] obs, input logic [31:0] esp);
      checks++;
      if (obs !== esp) begin
         errors++;
         $display("FAIL %s: got %0d, expected %0d", tag, obs, esp);
      end
   endtask

   // pl = pulse cycles still to come, gl = gap cycles still to come.
   task automatic modelo_paso(input int d);
      lost[d] = 1'b0;
      if (!rstn[d]) begin
         pl[d] = 0; gl[d] = 0; cuenta[d] = 0;
      end else if (pl[d] > 0) begin
         if (imp[d] && (RET_T[d] != 0)) begin
            pl[d] = ANCHO_T[d];
         end else begin
            lost[d] = imp[d];
            pl[d]--;
            if (pl[d] == 0) gl[d] = HUECO_T[d];
         end
      end else if (gl[d] > 0) begin
         lost[d] = imp[d];
         gl[d]--;
      end else if (imp[d]) begin
         pl[d] = ANCHO_T[d];
         cuenta[d] = (cuenta[d] + 1) % 256;
      end
   endtask

   task automatic ciclo();
      trio_t t;
      for (int d = 0; d < 3; d++) begin
         modelo_paso(d);
         t[d].p = (pl[d] > 0);
         t[d].o = (pl[d] > 0) || (gl[d] > 0);
         t[d].l = lost[d];
         t[d].c = 8'(cuenta[d]);
      end
      sb.push_back(t);
      @(posedge clk);
      #1;
      t = sb.pop_front();
      for (int d = 0; d < 3; d++) begin
         chequear({nombres[d], " pulso"},   32'(pul[d]), 32'(t[d].p));
         chequear({nombres[d], " ocupado"}, 32'(ocu[d]), 32'(t[d].o));
         chequear({nombres[d], " perdido"}, 32'(per[d]), 32'(t[d].l));
         chequear({nombres[d], " cuenta"},  32'(cnt[d]), 32'(t[d].c));
         hi_p[d] += int'(pul[d]);
         hi_o[d] += int'(ocu[d]);
         hi_l[d] += int'(per[d]);
         if (imp[d])
            $display("tx t=%0t dut=%s impulso=1 -> pulso=%0b ocupado=%0b perdido=%0b cuenta=%0d",
                     $time, nombres[d], pul[d], ocu[d], per[d], cnt[d]);
      end
      @(negedge clk);
   endtask

   task automatic limpiar();
      for (int d = 0; d < 3; d++) begin
         hi_p[d] = 0; hi_o[d] = 0; hi_l[d] = 0;
      end
   endtask

   initial begin
      #200000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   initial begin
      rstn = '0;
      imp  = '0;
      for (int d = 0; d < 3; d++) begin
         pl[d] = 0; gl[d] = 0; cuenta[d] = 0; lost[d] = 1'b0;
      end
      limpiar();
      repeat (2) @(negedge clk);
      for (int d = 0; d < 3; d++) begin
         chequear({nombres[d], " reset pulso"},   32'(pul[d]), 0);
         chequear({nombres[d], " reset ocupado"}, 32'(ocu[d]), 0);
         chequear({nombres[d], " reset perdido"}, 32'(per[d]), 0);
         chequear({nombres[d], " reset cuenta"},  32'(cnt[d]), 0);
      end
      rstn = '1;
      repeat (3) ciclo();

      // Single impulse on A
      limpiar();
      imp[0] = 1'b1; ciclo(); imp[0] = 1'b0;
      repeat (9) ciclo();
      chequear("A single pulse length", 32'(hi_p[0]), 4);
      chequear("A single busy length",  32'(hi_o[0]), 6);
      chequear("A single lost",         32'(hi_l[0]), 0);
      chequear("A single count",        32'(cnt[0]),  1);

      // Rejections in ACTIVO, at end of pulse and in HUECO, then accept
      limpiar();
      for (int i = 0; i < 16; i++) begin
         imp[0] = (i == 0 || i == 2 || i == 4 || i == 5 || i == 7);
         ciclo();
      end
      imp[0] = 1'b0;
      chequear("A reject pulse cycles", 32'(hi_p[0]), 8);
      chequear("A reject busy cycles",  32'(hi_o[0]), 12);
      chequear("A reject lost",         32'(hi_l[0]), 3);
      chequear("A reject count",        32'(cnt[0]),  3);

      // Retrigger on B
      limpiar();
      for (int i = 0; i < 12; i++) begin
         imp[1] = (i == 0 || i == 2);
         ciclo();
      end
      imp[1] = 1'b0;
      chequear("B retrig pulse cycles", 32'(hi_p[1]), 6);
      chequear("B retrig lost",         32'(hi_l[1]), 0);
      chequear("B retrig count",        32'(cnt[1]),  1);

      // Level input on C with minimum width
      limpiar();
      imp[2] = 1'b1;
      repeat (20) ciclo();
      imp[2] = 1'b0;
      repeat (3) ciclo();
      chequear("C level pulse cycles", 32'(hi_p[2]), 10);
      chequear("C level lost",         32'(hi_l[2]), 10);
      chequear("C level count",        32'(cnt[2]),  10);

      // Asynchronous reset in the middle of a pulse on A
      imp[0] = 1'b1; ciclo(); imp[0] = 1'b0;
      repeat (2) ciclo();
      chequear("A pulse before reset", 32'(pul[0]), 1);
      rstn[0] = 1'b0;
      #1;
      chequear("A async rst pulso",   32'(pul[0]), 0);
      chequear("A async rst ocupado", 32'(ocu[0]), 0);
      chequear("A async rst perdido", 32'(per[0]), 0);
      chequear("A async rst cuenta",  32'(cnt[0]), 0);
      repeat (2) ciclo();
      rstn[0] = 1'b1;
      repeat (4) ciclo();
      chequear("A idle after reset", 32'(ocu[0]), 0);

      // Count wrap on C
      rstn[2] = 1'b0; ciclo(); rstn[2] = 1'b1;
      for (int i = 0; i < 255; i++) begin
         imp[2] = 1'b1; ciclo();
         imp[2] = 1'b0; ciclo();
      end
      chequear("C count 255", 32'(cnt[2]), 255);
      imp[2] = 1'b1; ciclo();
      chequear("C count wrap", 32'(cnt[2]), 0);
      chequear("C pulse at wrap", 32'(pul[2]), 1);
      imp[2] = 1'b0; repeat (2) ciclo();

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
